// File: rtl/dfd_trace_sink.sv
// dfd_trace_sink: pulls trace words, places them in a circular stream of frames,
// and hands address/data pairs to the memory write port through a 2-entry buffer.
module dfd_trace_sink #(
  parameter int FIFO_WIDTH_IN_BYTES   = 16,
  parameter int FRAME_LENGTH_IN_BYTES = 512,
  parameter int MAX_STREAM_DEPTH      = 16,
  parameter int ADDR_WIDTH            = 40
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 tnif_req_in,
  output logic                                 tnif_data_pull_out,
  input  logic [FIFO_WIDTH_IN_BYTES*8-1:0]     tnif_data_in,
  input  logic                                 trace_enable,
  input  logic                                 clear_ptrs,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [$clog2(MAX_STREAM_DEPTH):0]    stream_depth,
  output logic                                 mem_wr_valid,
  input  logic                                 mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]                mem_wr_addr,
  output logic [FIFO_WIDTH_IN_BYTES*8-1:0]     mem_wr_data,
  output logic                                 frame_done,
  output logic                                 stream_wrap,
  output logic                                 stream_wrapped,
  output logic [$clog2(MAX_STREAM_DEPTH)-1:0]  frame_idx,
  output logic                                 sink_idle
);
  localparam int DW    = FIFO_WIDTH_IN_BYTES * 8;
  localparam int BEATS = FRAME_LENGTH_IN_BYTES / FIFO_WIDTH_IN_BYTES;
  localparam int BW    = $clog2(BEATS);
  localparam int FW    = $clog2(MAX_STREAM_DEPTH);
  localparam int SW    = FW + 1;

  logic [BW-1:0]         beat_q, beat_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  wrapped_q, wrapped_d, done_q, done_d, wrap_q, wrap_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [DW-1:0]         data_q [2];
  logic [SW-1:0]         depth;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic                  last_beat, last_frame, pull, pop;

  // depth is clamped to [1, MAX] so frame_idx never overflows its counter silently;
  // last_frame uses >= so a shrunk depth still wraps at the next frame boundary.
  always_comb begin
    depth      = stream_depth == '0 ? SW'(1)
               : stream_depth > SW'(MAX_STREAM_DEPTH) ? SW'(MAX_STREAM_DEPTH) : stream_depth;
    last_beat  = beat_q == BW'(BEATS - 1);
    last_frame = {1'b0, frame_q} >= depth - SW'(1);
    pull       = tnif_req_in & trace_enable & (cnt_q < 2'd2) & ~clear_ptrs;
    pop        = (cnt_q != 2'd0) & mem_wr_ready;
    push_addr  = base_addr + ADDR_WIDTH'(frame_q) * ADDR_WIDTH'(FRAME_LENGTH_IN_BYTES)
               + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(FIFO_WIDTH_IN_BYTES);
    beat_d     = clear_ptrs ? '0 : pull ? (last_beat ? '0 : beat_q + BW'(1)) : beat_q;
    frame_d    = clear_ptrs ? '0 : (pull & last_beat) ? (last_frame ? '0 : frame_q + FW'(1)) : frame_q;
    done_d     = pull & last_beat;
    wrap_d     = pull & last_beat & last_frame;
    wrapped_d  = ~clear_ptrs & (wrapped_q | wrap_d);
    cnt_d      = cnt_q + {1'b0, pull} - {1'b0, pop};
    rd_d       = rd_q ^ pop;
    wr_d       = wr_q ^ pull;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q    <= '0;
      frame_q   <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      beat_q    <= beat_d;
      frame_q   <= frame_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      if (pull) begin
        addr_q[wr_q] <= push_addr;
        data_q[wr_q] <= tnif_data_in;
      end
    end
  end

  assign tnif_data_pull_out = pull;
  assign mem_wr_valid       = cnt_q != 2'd0;
  assign mem_wr_addr        = addr_q[rd_q];
  assign mem_wr_data        = data_q[rd_q];
  assign frame_done         = done_q;
  assign stream_wrap        = wrap_q;
  assign stream_wrapped     = wrapped_q;
  assign frame_idx          = frame_q;
  assign sink_idle          = ~tnif_req_in & (cnt_q == 2'd0);
endmodule

// File: tb/tb_dfd_trace_sink.sv
// tb_dfd_trace_sink: table-driven stream scenarios plus hand sequences for stall,
// clear, enable drop and asynchronous reset of dfd_trace_sink.
module tb_dfd_trace_sink;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         tnif_req_in, tnif_data_pull_out, trace_enable, clear_ptrs;
  logic [127:0] tnif_data_in, mem_wr_data;
  logic [39:0]  base_addr, mem_wr_addr;
  logic [4:0]   stream_depth;
  logic         mem_wr_valid, mem_wr_ready, frame_done, stream_wrap, stream_wrapped, sink_idle;
  logic [3:0]   frame_idx;

  dfd_trace_sink dut (
    .clock(clock), .reset_n(reset_n), .tnif_req_in(tnif_req_in),
    .tnif_data_pull_out(tnif_data_pull_out), .tnif_data_in(tnif_data_in),
    .trace_enable(trace_enable), .clear_ptrs(clear_ptrs), .base_addr(base_addr),
    .stream_depth(stream_depth), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .frame_done(frame_done),
    .stream_wrap(stream_wrap), .stream_wrapped(stream_wrapped), .frame_idx(frame_idx),
    .sink_idle(sink_idle)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] a;
    logic [127:0] d;
  } ent_t;

  typedef struct {
    logic [39:0] base;
    logic [4:0]  depth;
    int          n;
    logic [39:0] last_addr;
    int          dones;
    int          wraps;
    logic [3:0]  fidx;
    logic        wrapped;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  int          npull = 0, dones = 0, wraps = 0, push_k = 0;
  int unsigned push_ser = 0, pop_ser = 0;
  ent_t        exp_q[$];
  logic [39:0] pop_log[$];
  vec_t        tbl[5];

  function automatic logic [127:0] data_of(input int unsigned s);
    return {s ^ 32'hA5A5_5A5A, ~s, s, 32'hC0DE_0000 + s};
  endfunction

  // Reference address: linear word offset modulo the stream size.
  function automatic logic [39:0] exp_addr(input int k);
    int eff;
    eff = stream_depth == 0 ? 1 : int'(stream_depth);
    return base_addr + 40'((k % (eff * 32)) * 16);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    ent_t e;
    tnif_data_in = data_of(push_ser);
    #1;
    if (mem_wr_valid && mem_wr_ready) begin
      if (exp_q.size() == 0) chk("wr_unexpected", {88'd0, mem_wr_addr}, 128'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", {88'd0, mem_wr_addr}, {88'd0, e.a});
        chk("wr_data", mem_wr_data, e.d);
      end
      pop_log.push_back(mem_wr_addr);
      pop_ser++;
    end
    if (tnif_data_pull_out) begin
      exp_q.push_back('{exp_addr(push_k), data_of(push_ser)});
      push_k++;
      push_ser++;
      npull++;
    end
    @(posedge clock);
    #1;
    dones += int'(frame_done);
    wraps += int'(stream_wrap);
  endtask

  task automatic run(input int n, output int cyc);
    int p0;
    p0 = npull;
    cyc = 0;
    trace_enable = 1'b1;
    mem_wr_ready = 1'b1;
    while ((npull - p0 < n || mem_wr_valid) && cyc < 2000) begin
      tnif_req_in = (npull - p0) < n;
      step();
      cyc++;
    end
    tnif_req_in = 1'b0;
    chk("run_in_budget", cyc < 2000, 1);
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic stall(input int ncyc);
    tnif_req_in = 1'b1;
    trace_enable = 1'b1;
    mem_wr_ready = 1'b0;
    repeat (ncyc) step();
    tnif_req_in = 1'b0;
  endtask

  task automatic clear_pulse();
    int p0;
    p0 = npull;
    tnif_req_in = 1'b1;
    trace_enable = 1'b1;
    clear_ptrs = 1'b1;
    step();
    clear_ptrs = 1'b0;
    tnif_req_in = 1'b0;
    push_k = 0;
    chk("clear_blocks_pull", npull - p0, 0);
  endtask

  initial begin
    int cyc, p0, bad;
    int unsigned s0;
    tbl[0] = '{40'h00_0000_1000, 5'd2,  64,  40'h00_0000_13F0, 2,  1, 4'd0, 1'b1};
    tbl[1] = '{40'h00_0000_1000, 5'd0,  40,  40'h00_0000_1070, 1,  1, 4'd0, 1'b1};
    tbl[2] = '{40'h00_0002_0000, 5'd3,  50,  40'h00_0002_0310, 1,  0, 4'd1, 1'b0};
    tbl[3] = '{40'hFF_FFFF_FE00, 5'd4,  40,  40'h00_0000_0070, 1,  0, 4'd1, 1'b0};
    tbl[4] = '{40'h00_0000_4000, 5'd16, 512, 40'h00_0000_5FF0, 16, 1, 4'd0, 1'b1};

    reset_n = 1'b0; tnif_req_in = 1'b0; trace_enable = 1'b0; clear_ptrs = 1'b0;
    tnif_data_in = '0; base_addr = 40'h1000; stream_depth = 5'd2; mem_wr_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", mem_wr_valid, 0);
    chk("rst_addr", {88'd0, mem_wr_addr}, 0);
    chk("rst_data", mem_wr_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_wrap", stream_wrap, 0);
    chk("rst_wrapped", stream_wrapped, 0);
    chk("rst_fidx", frame_idx, 0);
    chk("rst_pull_idle", tnif_data_pull_out, 0);
    chk("rst_sink_idle", sink_idle, 1);
    tnif_req_in = 1'b1; trace_enable = 1'b1;
    #1;
    chk("rst_pull_req", tnif_data_pull_out, 1);
    chk("rst_sink_busy", sink_idle, 0);
    tnif_req_in = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      base_addr = tbl[i].base;
      stream_depth = tbl[i].depth;
      clear_pulse();
      dones = 0; wraps = 0;
      pop_log.delete();
      run(tbl[i].n, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, tbl[i].n + 1);
      chk($sformatf("v%0d_first", i), {88'd0, pop_log[0]}, {88'd0, tbl[i].base});
      chk($sformatf("v%0d_last", i), {88'd0, pop_log[pop_log.size()-1]}, {88'd0, tbl[i].last_addr});
      chk($sformatf("v%0d_dones", i), dones, tbl[i].dones);
      chk($sformatf("v%0d_wraps", i), wraps, tbl[i].wraps);
      chk($sformatf("v%0d_fidx", i), frame_idx, tbl[i].fidx);
      chk($sformatf("v%0d_wrapped", i), stream_wrapped, tbl[i].wrapped);
      chk($sformatf("v%0d_idle", i), sink_idle, 1);
    end

    // Backpressure: two pulls then hold, head stays put, then resume.
    base_addr = 40'h1000; stream_depth = 5'd2;
    clear_pulse();
    p0 = npull; bad = 0; s0 = push_ser;
    tnif_req_in = 1'b1; trace_enable = 1'b1; mem_wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(mem_wr_valid && mem_wr_addr == 40'h1000 && mem_wr_data == data_of(s0))) bad++;
    end
    chk("stall_pulls", npull - p0, 2);
    chk("stall_head_stable", bad, 0);
    chk("stall_pull_low", tnif_data_pull_out, 0);
    tnif_req_in = 1'b0;
    pop_log.delete();
    run(8, cyc);
    chk("resume_cycles", cyc, 10);
    chk("resume_count", pop_log.size(), 10);
    chk("resume_first", {88'd0, pop_log[0]}, 128'h1000);
    chk("resume_last", {88'd0, pop_log[9]}, 128'h1090);

    // clear_ptrs with two words buffered after a wrap.
    clear_pulse();
    run(84, cyc);
    stall(2);
    chk("clr_pre_wrapped", stream_wrapped, 1);
    clear_pulse();
    chk("clr_fidx", frame_idx, 0);
    chk("clr_wrapped", stream_wrapped, 0);
    chk("clr_keeps_buf", mem_wr_valid, 1);
    pop_log.delete();
    run(1, cyc);
    chk("clr_drain0", {88'd0, pop_log[0]}, 128'h1140);
    chk("clr_drain1", {88'd0, pop_log[1]}, 128'h1150);
    chk("clr_next", {88'd0, pop_log[2]}, 128'h1000);

    // trace_enable dropped at beat 7.
    clear_pulse();
    run(7, cyc);
    p0 = npull;
    tnif_req_in = 1'b1; trace_enable = 1'b0; mem_wr_ready = 1'b1;
    repeat (5) step();
    chk("en_off_pulls", npull - p0, 0);
    chk("en_off_fidx", frame_idx, 0);
    chk("en_off_busy", sink_idle, 0);
    tnif_req_in = 1'b0;
    pop_log.delete();
    run(1, cyc);
    chk("en_resume_addr", {88'd0, pop_log[0]}, 128'h1070);

    // Asynchronous reset with two words buffered in frame 1.
    clear_pulse();
    run(35, cyc);
    chk("ar_pre_fidx", frame_idx, 1);
    stall(2);
    chk("ar_pre_valid", mem_wr_valid, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_valid", mem_wr_valid, 0);
    chk("ar_fidx", frame_idx, 0);
    exp_q.delete();
    push_k = 0;
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    pop_log.delete();
    run(1, cyc);
    chk("ar_count", pop_log.size(), 1);
    chk("ar_first", {88'd0, pop_log[0]}, 128'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dfd_trace_sink.md
# dfd_trace_sink

Trace network interface sink that sits downstream of the trace packetizer FIFO. It pulls 16-byte trace words when the packetizer requests, and computes the memory address of each word inside a circular stream of fixed-length frames. It then delivers address/data pairs to the memory write port through a 2-entry elastic buffer. It tracks frame and stream-wrap boundaries and reports them as status pulses and a sticky wrap flag.

## Interface
- FIFO_WIDTH_IN_BYTES, 16, bytes per trace word; must match the packetizer FIFO width.
- FRAME_LENGTH_IN_BYTES, 512, bytes per frame; must be a power of two and a multiple of FIFO_WIDTH_IN_BYTES.
- MAX_STREAM_DEPTH, 16, maximum number of frames in the circular stream.
- ADDR_WIDTH, 40, memory address width.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- tnif_req_in  in  1  packetizer FIFO non-empty.
- tnif_data_pull_out  out  1  pops the packetizer FIFO; data is taken in the same cycle.
- tnif_data_in  in  FIFO_WIDTH_IN_BYTES*8  packetizer FIFO head word.
- trace_enable  in  1  allows pulling.
- clear_ptrs  in  1  synchronous pulse; zeroes the frame/beat pointers and wrap flag.
- base_addr  in  ADDR_WIDTH  stream base address; must be aligned to FRAME_LENGTH_IN_BYTES.
- stream_depth  in  $clog2(MAX_STREAM_DEPTH)+1  frames in the stream; 0 is treated as 1.
- mem_wr_valid  out  1  write request valid.
- mem_wr_ready  in  1  write accepted.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  FIFO_WIDTH_IN_BYTES*8  write data.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is pulled.
- stream_wrap  out  1  one-cycle pulse when the last frame of the stream completes.
- stream_wrapped  out  1  sticky; set on the first wrap.
- frame_idx  out  $clog2(MAX_STREAM_DEPTH)  current frame index.
- sink_idle  out  1  no request pending and buffer empty.

## Operation
- BEATS = FRAME_LENGTH_IN_BYTES/FIFO_WIDTH_IN_BYTES. beat_idx counts 0..BEATS-1; frame_idx counts 0..depth-1, where depth = max(stream_depth,1).
- Pull: tnif_data_pull_out = tnif_req_in & trace_enable & (buf_cnt < 2) & ~clear_ptrs. The pull is purely combinational from the current state and inputs.
- Address on a pull: base_addr + frame_idx*FRAME_LENGTH_IN_BYTES + beat_idx*FIFO_WIDTH_IN_BYTES. The sum is computed at ADDR_WIDTH bits; bits above ADDR_WIDTH are dropped.
- A pull pushes {addr, tnif_data_in} into the 2-entry buffer.
- Pointer update on a pull:
  - beat_idx < BEATS-1: beat_idx increments.
  - beat_idx = BEATS-1: beat_idx goes to 0 and frame_done is asserted next cycle.
  - beat_idx = BEATS-1 and frame_idx = depth-1: frame_idx goes to 0, stream_wrap is asserted next cycle, and stream_wrapped is set.
  - beat_idx = BEATS-1 otherwise: frame_idx increments.
- Buffer:
  - In-order FIFO of 2 entries.
  - mem_wr_valid = (buf_cnt != 0); the head entry drives mem_wr_addr and mem_wr_data.
  - Pop on mem_wr_valid & mem_wr_ready.
  - A push and a pop in the same cycle leave buf_cnt unchanged.
  - The head entry is held stable while valid and not ready.
- clear_ptrs:
  - Zeroes beat_idx, frame_idx and stream_wrapped next cycle.
  - Blocks pulling in its own cycle.
  - Leaves buffer contents and the drain untouched.
- trace_enable low: pulling stops and the pointers hold. Buffered entries still drain.
- stream_depth changes take effect on the next frame boundary compare. If frame_idx ≥ depth when a frame completes, frame_idx goes to 0 with a wrap.
- sink_idle = ~tnif_req_in & (buf_cnt == 0).

## Timing
- Reset values:
  - tnif_data_pull_out follows its equation. It is 0 whenever tnif_req_in or trace_enable is low.
  - All other outputs are 0: mem_wr_valid, mem_wr_addr, mem_wr_data, frame_done, stream_wrap, stream_wrapped, frame_idx.
  - sink_idle follows ~tnif_req_in.
- Latency: a word pulled in cycle T appears on mem_wr_* in cycle T+1.
- Throughput: with mem_wr_ready held high, 1 word per cycle is sustained.
- Backpressure: with mem_wr_ready low, at most 2 words are pulled, then pulling stops until a pop.
- frame_done and stream_wrap are registered, asserted in cycle T+1 of the completing pull, and last exactly 1 cycle.
- Asynchronous reset mid-operation:
  - Buffered data is discarded and pointers return to 0.
  - mem_wr_valid drops immediately, without waiting for a clock edge.

## Test plan
- Base 0x1000, depth 2, ready high, 64 back-to-back words -> addresses 0x1000..0x13F0 in order. frame_done pulses after words 32 and 64. stream_wrap and stream_wrapped assert after word 64. frame_idx returns to 0.
- Hold mem_wr_ready low for 10 cycles with req high -> exactly 2 pulls, then pull stays 0. Head address/data are stable. Releasing ready resumes 1 word per cycle with no loss or duplication.
- stream_depth=0, 40 words -> behaves as depth 1. Wrap after word 32; word 33 is written at base_addr.
- clear_ptrs after word 20 with 2 words buffered -> both buffered words drain with their original addresses. The next pulled word goes to base_addr; stream_wrapped reads 0.
- trace_enable dropped mid-frame at beat 7 -> pull stops. On re-enable, the next word is written at beat 7 of the same frame.
- Assert reset_n low with 2 words buffered, between clock edges -> mem_wr_valid and frame_idx go to 0 asynchronously. After release, the first word goes to base_addr.
